seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 SHALL have port Clock, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset_b, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to execute op; sampled on the rising edge.
REQ-005 SHALL have port op, input, 3, operation select, sampled with start.
REQ-006 SHALL have port a, input, WIDTH, operand A.
REQ-007 SHALL have port b, input, WIDTH, operand B.
REQ-008 SHALL have port use_acc, input, 1: when 1, A is taken from result[WIDTH-1:0] instead of a.
REQ-009 SHALL have port result, output, 2*WIDTH, registered ALU result.
REQ-010 SHALL have port busy, output, 1, high while a multi-cycle operation runs.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when result is updated.
REQ-012 SHALL have port flag_zero, output, 1, registered (result == 0).
REQ-013 SHALL have port ovf, output, 1, registered carry/borrow of last add/sub.

Function
REQ-014 SHALL implement FSM states IDLE and MUL.
- IDLE: start & op!=3'b111 -> execute, stay IDLE.
- IDLE: start & op==3'b111 -> MUL.
- MUL: after exactly WIDTH cycles -> IDLE.
REQ-015 SHALL define effective A (Ae) as use_acc ? result[WIDTH-1:0] : a, captured with b and op at the accepting edge.
REQ-016 SHALL compute the op codes, all unsigned and zero-extended to 2*WIDTH:
- 000 add: Ae+b; ovf = carry out of bit WIDTH-1 (also present in result[WIDTH]).
- 001 sub: (Ae-b) mod 2^WIDTH; ovf = 1 iff Ae<b.
- 010 concat: {Ae,b}.
- 011 or-any: 1 iff (Ae|b)!=0.
- 100 and-any: 1 iff (Ae&b)!=0.
- 101 pass: b.
- 110 shift: {0,b} << Ae, truncated to 2*WIDTH bits; Ae >= 2*WIDTH gives 0.
- 111 mul: full 2*WIDTH-bit product Ae*b by iterative shift-add, one multiplier bit per cycle.
REQ-017 SHALL force ovf to 0 for every op other than add/sub.
REQ-018 Single-cycle ops SHALL have latency 1: on the edge that accepts start, result, flag_zero and ovf update, and done is high for the following cycle only.
REQ-019 mul SHALL raise busy from the accepting edge for exactly WIDTH cycles. On the WIDTH-th edge, result is written, busy falls and done goes high for one cycle.
REQ-020 result SHALL hold its previous value throughout MUL; intermediate partial products SHALL NOT be visible.
REQ-021 start while busy SHALL be ignored, with no effect on state, operands or outputs.
REQ-022 start in the cycle in which done is high SHALL be accepted (back-to-back ops, no bubble).
REQ-023 flag_zero SHALL be updated on the same edge as result.

Reset
REQ-024 Reset_b low SHALL immediately and asynchronously set: state IDLE, result 0, busy 0, done 0, ovf 0, flag_zero 1, iteration counter 0.
REQ-025 Reset asserted during MUL SHALL abort the operation and discard the partial product. After release, the first start SHALL behave as from power-up.
REQ-026 start SHALL be ignored while Reset_b is low.

Verification (WIDTH=4)
REQ-027 Add: a=9, b=8, op=000 -> result 0x11, ovf=1, done high for exactly one cycle after the accepting edge.
REQ-028 Sub: a=3, b=5, op=001 -> result 0x0E, ovf=1. Then a=5, b=3 -> result 0x02, ovf=0.
REQ-029 Mul: a=15, b=15, op=111 -> busy high for 4 cycles, result 0xE1 on the 4th edge with done pulse. A start (op=000) issued mid-busy is ignored.
REQ-030 Accumulate: with result=0x06, op=000, use_acc=1, a=0xF, b=2 -> result 0x08, ovf=0.
REQ-031 Shift: a=3, b=5, op=110 -> result 0x28. Then a=9, b=1 -> result 0x00, flag_zero=1.
REQ-032 Reset: Reset_b low during cycle 2 of mul(7,9) -> outputs take reset values without a clock edge. After release, mul(7,9) -> result 0x3F after 4 cycles.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus an iterative
// shift-add multiplier that retires one multiplier bit per clock.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_b,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 use_acc,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic                 flag_zero,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 done_reg;
  logic                 zero_reg;
  logic                 ovf_reg;

  logic [WIDTH-1:0]     ae;
  logic                 accept;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   mul_sum;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH-1:0]     diff_w;
  logic [31:0]          ae_ext;
  logic [2*WIDTH-1:0]   b_ext;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 alu_ovf;

  // Effective A comes from the low half of the current result when accumulating.
  assign ae       = use_acc ? result_reg[WIDTH-1:0] : a;
  assign accept   = start && (state_reg == IDLE);
  assign mul_last = (state_reg == MUL) && (cnt_reg == CW'(WIDTH - 1));
  // Partial product after folding in the current multiplier bit.
  assign mul_sum  = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign sum_w    = {1'b0, ae} + {1'b0, b};
  assign diff_w   = ae - b;
  assign ae_ext   = 32'(ae);
  assign b_ext    = {{WIDTH{1'b0}}, b};

  assign result    = result_reg;
  assign busy      = (state_reg == MUL);
  assign done      = done_reg;
  assign flag_zero = zero_reg;
  assign ovf       = ovf_reg;

  // State register.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state: multiply runs exactly WIDTH cycles, everything else stays IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start && (op == OP_MUL)) state_next = MUL;
      MUL:  if (mul_last)                state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ALU result and carry/borrow for the operation being accepted.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      3'b000: begin
        alu_res = {{(WIDTH-1){1'b0}}, sum_w};
        alu_ovf = sum_w[WIDTH];
      end
      3'b001: begin
        alu_res = {{WIDTH{1'b0}}, diff_w};
        alu_ovf = (ae < b);
      end
      3'b010: alu_res = {ae, b};
      3'b011: alu_res = {{(2*WIDTH-1){1'b0}}, |(ae | b)};
      3'b100: alu_res = {{(2*WIDTH-1){1'b0}}, |(ae & b)};
      3'b101: alu_res = b_ext;
      3'b110: alu_res = (ae_ext >= 32'(2*WIDTH)) ? '0 : (b_ext << ae);
      default: alu_res = '0;
    endcase
  end

  // Datapath: commit single-cycle results, or step the shift-add multiplier
  // and commit only the final product so partial sums never reach result.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      result_reg <= '0;
      done_reg   <= 1'b0;
      zero_reg   <= 1'b1;
      ovf_reg    <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          prod_reg   <= '0;
          mcand_reg  <= {{WIDTH{1'b0}}, ae};
          mplier_reg <= b;
          cnt_reg    <= '0;
        end else begin
          result_reg <= alu_res;
          zero_reg   <= (alu_res == '0);
          ovf_reg    <= alu_ovf;
          done_reg   <= 1'b1;
        end
      end else if (state_reg == MUL) begin
        prod_reg   <= mul_sum;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + 1'b1;
        if (mul_last) begin
          result_reg <= mul_sum;
          zero_reg   <= (mul_sum == '0);
          ovf_reg    <= 1'b0;
          done_reg   <= 1'b1;
          cnt_reg    <= '0;
        end
      end
    end
  end

endmodule
